// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one data-memory port between the CPU dbus (m0) and a DMA/display master (m1).
// Optional build macro DBUS_ARB_RR_EN selects round-robin instead of fixed priority plus starvation guard.
module dbus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_req_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_err_o,
  input  logic                m1_req_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_err_o,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);
  localparam logic [9:0]        TO_LAST  = 10'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [9:0] to_q, to_d;

  logic              pick1;
  logic              any_req;
  logic              gnt0, gnt1;
  logic              resp_v;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

`ifdef DBUS_ARB_RR_EN
  logic rr_q, rr_d;

  // rr_q remembers the last granted master; the other one wins a tie
  always_comb begin
    pick1 = 1'b0;
    unique case (1'b1)
      m0_req_i && m1_req_i: pick1 = ~rr_q;
      m1_req_i:             pick1 = 1'b1;
      default:              pick1 = 1'b0;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt0) rr_d = 1'b0;
    if (gnt1) rr_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rr_q <= 1'b1;
    else         rr_q <= rr_d;
  end
`else
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [7:0] wait_q, wait_d;
  logic       starve;

  assign starve = (wait_q == WAIT_MAX);

  always_comb begin
    pick1 = 1'b0;
    unique case (1'b1)
      m1_req_i && (!m0_req_i || starve): pick1 = 1'b1;
      default:                           pick1 = 1'b0;
    endcase
  end

  // counts cycles m1 is left waiting, also while a read holds the port
  always_comb begin
    wait_d = 8'd0;
    if (m1_req_i && !gnt1) begin
      wait_d = starve ? wait_q : wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) wait_q <= 8'd0;
    else         wait_q <= wait_d;
  end
`endif

  assign any_req = m0_req_i | m1_req_i;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    to_d        = to_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    resp_v      = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt0        = ~pick1;
          gnt1        = pick1;
          mem_req_o   = 1'b1;
          mem_addr_o  = pick1 ? m1_addr_i  : m0_addr_i;
          mem_we_o    = pick1 ? m1_we_i    : m0_we_i;
          mem_wdata_o = pick1 ? m1_wdata_i : m0_wdata_i;
          mem_wstrb_o = pick1 ? m1_wstrb_i : m0_wstrb_i;
          if (!mem_we_o) begin
            state_d = RD_WAIT;
            owner_d = pick1;
            to_d    = 10'd0;
          end
        end
      end
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          resp_v    = 1'b1;
          resp_data = mem_rdata_i;
          state_d   = IDLE;
        end else if (to_q == TO_LAST) begin
          resp_v    = 1'b1;
          resp_err  = 1'b1;
          resp_data = ERR_DATA;
          state_d   = IDLE;
        end else begin
          to_d = to_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // everything facing the masters and memory is quiet while in reset
    if (!rst_ni) begin
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      resp_v      = 1'b0;
      resp_err    = 1'b0;
      resp_data   = '0;
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      mem_wstrb_o = '0;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign m0_rvalid_o = resp_v & ~owner_q;
  assign m1_rvalid_o = resp_v & owner_q;
  assign m0_err_o    = resp_err & ~owner_q;
  assign m1_err_o    = resp_err & owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? resp_data : '0;
  assign m1_rdata_o  = m1_rvalid_o ? resp_data : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      to_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed vectors for dbus_arbiter with MAX_WAIT=4, TIMEOUT=8.
// Expectations follow DBUS_ARB_RR_EN when the bench is built with that macro.
module tb_dbus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          m0_gnt, m0_rvalid, m0_err;
  logic          m1_gnt, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_req, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [5:0] pat;
  logic [5:0] pat_exp;

  initial begin
`ifdef DBUS_ARB_RR_EN
    pat_exp = 6'b101010;
`else
    pat_exp = 6'b010000;
`endif
    rst_ni = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10;
    m0_wdata = 32'hA0; m0_wstrb = 4'hF;
    m1_req = 1'b0; m1_we = 1'b1; m1_addr = 32'h20;
    m1_wdata = 32'hB0; m1_wstrb = 4'h3;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    cyc();
    @(negedge clk);
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 0);

    // both masters write continuously from the first cycle after reset
    cyc();
    rst_ni = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = m1_gnt;
      if (i == 0) chk("first_gnt0", m0_gnt, 1);
      if (i == 4) begin
        chk("arb_addr", mem_addr, pat_exp[4] ? 32'h20 : 32'h10);
        chk("arb_strb", mem_wstrb, pat_exp[4] ? 4'h3 : 4'hF);
      end
      cyc();
    end
    chk("arb_pattern", pat, pat_exp);

    m1_req = 1'b0;
    m0_addr = 32'h100; m0_wdata = 32'h777; m0_wstrb = 4'hF;
    @(negedge clk);
    chk("wr_gnt", m0_gnt, 1);
    chk("wr_mem", {mem_req, mem_we, mem_addr, mem_wdata},
        {1'b1, 1'b1, 32'h100, 32'h777});
    cyc();
    m0_addr = 32'h104;
    @(negedge clk);
    chk("wr2_gnt", {m0_gnt, mem_addr}, {1'b1, 32'h104});
    cyc();

    m0_we = 1'b0; m0_addr = 32'h200;
    @(negedge clk);
    chk("rd_gnt", {m0_gnt, mem_req, mem_we}, 3'b110);
    cyc();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h300;
    @(negedge clk);
    chk("rd_wait_block", {m1_gnt, mem_req}, 2'b00);
    cyc();
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rd_resp", {m0_rvalid, m0_rdata}, {1'b1, 32'h1234_5678});
    chk("rd_other", {m1_rvalid, m1_rdata, m1_gnt, m0_err}, 0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    chk("rd_after_gnt1", {m1_gnt, mem_addr}, {1'b1, 32'h300});
    chk("rd_rdata_idle", {m0_rvalid, m0_rdata}, 0);
    cyc();

    m1_we = 1'b0; m1_addr = 32'h400;
    @(negedge clk);
    chk("to_gnt1", m1_gnt, 1);
    cyc();
    m1_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) chk("to_early", m1_rvalid, 0);
      if (k == 8) begin
        chk("to_resp", {m1_rvalid, m1_err, m1_rdata},
            {1'b1, 1'b1, 32'hDEAD_BEEF});
        chk("to_other", {m0_rvalid, m0_err}, 0);
      end
      cyc();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h5555;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h500;
    @(negedge clk);
    chk("late_rvalid", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 0);
    chk("late_gnt0", m0_gnt, 1);
    cyc();
    mem_rvalid = 1'b0;

    m0_we = 1'b0; m0_addr = 32'h600;
    @(negedge clk);
    chk("rr_rd_gnt", m0_gnt, 1);
    cyc();
    m0_addr = 32'h604;
    rst_ni = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111;
    @(negedge clk);
    chk("rst_rd_out", {m0_gnt, mem_req, m0_rvalid, m0_rdata}, 0);
    cyc();
    rst_ni = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_rel_gnt", {m0_gnt, mem_addr}, {1'b1, 32'h604});
    cyc();
    m0_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    @(negedge clk);
    chk("rst_rel_resp", {m0_rvalid, m0_rdata}, {1'b1, 32'hCAFE});
    cyc();
    mem_rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
